// File: rtl/wb_burst_reader.sv
// Wishbone incrementing-burst reader feeding a word FIFO drained by a valid/ready stream.
// Bus starts one cycle after request acceptance; stb is withheld whenever the FIFO would be full.
module wb_burst_reader #(
  parameter int BUF_ADDR_BITS = 4,
  parameter int LEN_BITS      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [29:0]         req_addr,
  input  logic [LEN_BITS-1:0] req_len,
  output logic                done,
  output logic                err,
  output logic                out_valid,
  output logic [31:0]         out_data,
  input  logic                out_ready,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic [29:0]         wbm_addr_o,
  output logic [2:0]          wbm_cti_o,
  output logic [1:0]          wbm_bte_o,
  output logic [3:0]          wbm_sel_o,
  output logic                wbm_we_o,
  input  logic [31:0]         wbm_data_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i
);

  localparam int DEPTH = 1 << BUF_ADDR_BITS;
  localparam logic [BUF_ADDR_BITS:0] FULL = {1'b1, {BUF_ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [29:0]         addr_q, addr_d;
  logic [LEN_BITS-1:0] rem_q, rem_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                err_q, err_d;
  logic                rdy_q, rdy_d;

  logic [BUF_ADDR_BITS:0] wr_ptr_q, rd_ptr_q;
  logic [BUF_ADDR_BITS:0] count, count_nxt;
  logic [31:0]            mem_q [DEPTH];

  logic beat, abort, push, pop;

  // An error termination wins over a simultaneous ack: that beat is discarded.
  assign abort = stb_q & wbm_err_i;
  assign beat  = stb_q & wbm_ack_i & ~wbm_err_i;
  assign push  = beat;
  assign pop   = out_valid & out_ready;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign count_nxt = count + {{BUF_ADDR_BITS{1'b0}}, push} - {{BUF_ADDR_BITS{1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && rdy_q) begin
          addr_d  = req_addr;
          rem_d   = req_len;
          err_d   = 1'b0;
          state_d = (req_len == '0) ? S_DONE : S_BURST;
        end
      end
      S_BURST: begin
        if (abort) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = S_DONE;
        end else if (beat && rem_q == LEN_BITS'(1)) begin
          addr_d  = addr_q + 30'd1;
          rem_d   = '0;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          if (beat) begin
            addr_d = addr_q + 30'd1;
            rem_d  = rem_q - LEN_BITS'(1);
          end
          // Only strobe when the word it may fetch is guaranteed a slot.
          cyc_d = 1'b1;
          stb_d = (rem_d != '0) && (count_nxt != FULL);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
      wr_ptr_q <= wr_ptr_q + {{BUF_ADDR_BITS{1'b0}}, push};
      rd_ptr_q <= rd_ptr_q + {{BUF_ADDR_BITS{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[BUF_ADDR_BITS-1:0]] <= wbm_data_i;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q[BUF_ADDR_BITS-1:0]] : 32'h0;

  assign req_ready  = rdy_q;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_addr_o = addr_q;
  assign wbm_cti_o  = cyc_q ? ((rem_q == LEN_BITS'(1)) ? 3'b111 : 3'b010) : 3'b000;
  assign wbm_bte_o  = 2'b00;
  assign wbm_sel_o  = 4'b1111;
  assign wbm_we_o   = 1'b0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Randomized bench for wb_burst_reader: behavioural slave/consumer plus a linear-burst reference model.
module tb_wb_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [29:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic        req_ready, done, err, out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [29:0] wbm_addr_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_data_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;

  wb_burst_reader #(.BUF_ADDR_BITS(4), .LEN_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .done(done), .err(err),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_addr_o(wbm_addr_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_data_i(wbm_data_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ack_pct = 100;
  int rdy_pct = 100;
  int err_beat = 0;
  int beat_num = 0;
  int cyc_cnt = 0;
  int wait_cnt = 0;
  int done_cnt = 0;
  time acc_t = 0;
  time done_t = 0;
  logic [31:0] seed = 32'h1234_5678;
  logic [29:0] obs_addr[$];
  logic [2:0]  obs_cti[$];
  logic [31:0] obs_data[$];

  // Slave memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] slave_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ seed;
  endfunction

  // Slave, consumer and bus observer, all acting on the falling edge.
  initial begin
    bit roll;
    forever begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_stb_o) begin
        roll = (int'($urandom_range(99)) < ack_pct);
        wbm_data_i = slave_word(wbm_addr_o);
        if (roll && err_beat != 0 && beat_num + 1 == err_beat) begin
          wbm_err_i = 1'b1;
          wbm_ack_i = 1'b0;
        end else begin
          wbm_err_i = 1'b0;
          wbm_ack_i = roll;
        end
      end else begin
        wbm_ack_i  = 1'b0;
        wbm_err_i  = 1'b0;
        wbm_data_i = $urandom;
      end
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
        beat_num++;
        obs_addr.push_back(wbm_addr_o);
        obs_cti.push_back(wbm_cti_o);
      end
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      if (out_valid && out_ready) obs_data.push_back(out_data);
      if (wbm_cyc_o) cyc_cnt++;
      if (wbm_cyc_o && !wbm_stb_o) wait_cnt++;
      if (done) begin
        done_cnt++;
        done_t = $time;
      end
    end
  end

  task automatic start_req(input logic [29:0] a, input logic [7:0] n);
    int k;
    obs_addr.delete();
    obs_cti.delete();
    obs_data.delete();
    beat_num = 0;
    cyc_cnt  = 0;
    wait_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = n;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_accept req_ready=%b required=1", req_ready);
    end
    @(posedge clk);
    acc_t = $time;
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input bit drain);
    int k;
    k = 0;
    while (k < 3000 && !(done_cnt != 0 && (!drain || (!out_valid && req_ready)))) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      failures++;
      $display("FAIL wait_done timeout done_cnt=%0d out_valid=%b required done and drained", done_cnt, out_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  // One complete transfer checked beat by beat against the linear-burst model.
  task automatic test_transfer(input logic [29:0] a, input logic [7:0] n, input int ap, input int rp);
    int nn;
    logic [29:0] ea;
    logic [2:0]  ec;
    logic [31:0] ed;
    ack_pct = ap;
    rdy_pct = rp;
    err_beat = 0;
    nn = int'(n);
    start_req(a, n);
    wait_done(1'b1);
    checks++;
    if (obs_addr.size() != nn || obs_data.size() != nn) begin
      failures++;
      $display("FAIL xfer_count beats=%0d words=%0d required=%0d", obs_addr.size(), obs_data.size(), nn);
    end
    for (int i = 0; i < nn && i < obs_addr.size() && i < obs_data.size(); i++) begin
      ea = a + 30'(i);
      ec = (i == nn - 1) ? 3'b111 : 3'b010;
      ed = slave_word(ea);
      checks++;
      if (obs_addr[i] !== ea || obs_cti[i] !== ec || obs_data[i] !== ed) begin
        failures++;
        $display("FAIL xfer_beat%0d addr=%h cti=%b data=%h required addr=%h cti=%b data=%h",
                 i, obs_addr[i], obs_cti[i], obs_data[i], ea, ec, ed);
      end
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL xfer_end done_pulses=%0d err=%b required 1 and 0", done_cnt, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, wbm_cyc_o, wbm_stb_o, done, err, out_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags rdy,cyc,stb,done,err,vld=%b required 000000",
               {req_ready, wbm_cyc_o, wbm_stb_o, done, err, out_valid});
    end
    checks++;
    if (wbm_addr_o !== 30'h0 || wbm_cti_o !== 3'b000 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_values addr=%h cti=%b data=%h required 0", wbm_addr_o, wbm_cti_o, out_data);
    end
    checks++;
    if ({wbm_bte_o, wbm_sel_o, wbm_we_o} !== 7'b00_1111_0) begin
      failures++;
      $display("FAIL reset_consts bte,sel,we=%b required 0011110", {wbm_bte_o, wbm_sel_o, wbm_we_o});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_basic();
    seed = $urandom;
    test_transfer(30'h100, 8'd4, 100, 100);
    checks++;
    if (cyc_cnt != 4 || wait_cnt != 0) begin
      failures++;
      $display("FAIL basic_cyc cycles=%0d waits=%0d required 4 and 0", cyc_cnt, wait_cnt);
    end
    checks++;
    if (done_t - acc_t != 55) begin
      failures++;
      $display("FAIL basic_done_time delta=%0t required 55", done_t - acc_t);
    end
  endtask

  task automatic test_len_zero();
    test_transfer(30'($urandom), 8'd0, 100, 100);
    checks++;
    if (cyc_cnt != 0) begin
      failures++;
      $display("FAIL len0_cyc cycles=%0d required 0", cyc_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [29:0] a;
    logic [29:0] ea;
    int k;
    seed = $urandom;
    a = 30'($urandom);
    ack_pct = 100;
    rdy_pct = 0;
    err_beat = 0;
    start_req(a, 8'd40);
    k = 0;
    while (obs_addr.size() < 16 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs_addr.size() != 16) begin
      failures++;
      $display("FAIL bp_stall_beats beats=%0d required 16", obs_addr.size());
    end
    checks++;
    if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_stall_bus cyc=%b stb=%b vld=%b required 1,0,1", wbm_cyc_o, wbm_stb_o, out_valid);
    end
    rdy_pct = 100;
    wait_done(1'b1);
    checks++;
    if (obs_addr.size() != 40 || obs_data.size() != 40) begin
      failures++;
      $display("FAIL bp_count beats=%0d words=%0d required 40", obs_addr.size(), obs_data.size());
    end
    for (int i = 0; i < 40 && i < obs_addr.size() && i < obs_data.size(); i++) begin
      ea = a + 30'(i);
      checks++;
      if (obs_addr[i] !== ea || obs_data[i] !== slave_word(ea)) begin
        failures++;
        $display("FAIL bp_beat%0d addr=%h data=%h required addr=%h data=%h",
                 i, obs_addr[i], obs_data[i], ea, slave_word(ea));
      end
    end
  endtask

  task automatic test_error();
    logic [29:0] a;
    seed = $urandom;
    a = 30'($urandom);
    ack_pct = 100;
    rdy_pct = 0;
    err_beat = 3;
    start_req(a, 8'd8);
    wait_done(1'b0);
    checks++;
    if (obs_addr.size() != 2 || done_cnt != 1) begin
      failures++;
      $display("FAIL err_beats beats=%0d done_pulses=%0d required 2 and 1", obs_addr.size(), done_cnt);
    end
    checks++;
    if (err !== 1'b1 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL err_state err=%b cyc=%b stb=%b vld=%b required 1,0,0,1", err, wbm_cyc_o, wbm_stb_o, out_valid);
    end
    rdy_pct = 100;
    repeat (6) @(negedge clk);
    checks++;
    if (obs_data.size() != 2 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_fifo words=%0d vld=%b required 2 and 0", obs_data.size(), out_valid);
    end
    for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== slave_word(a + 30'(i))) begin
        failures++;
        $display("FAIL err_word%0d data=%h required %h", i, obs_data[i], slave_word(a + 30'(i)));
      end
    end
    err_beat = 0;
    start_req(a + 30'd100, 8'd3);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear err=%b required 0", err);
    end
    wait_done(1'b1);
    checks++;
    if (obs_data.size() != 3 || done_cnt != 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL err_next words=%0d done_pulses=%0d err=%b required 3,1,0", obs_data.size(), done_cnt, err);
    end
  endtask

  task automatic test_wrap();
    seed = $urandom;
    test_transfer(30'h3FFF_FFFF, 8'd2, 100, 100);
    test_transfer(30'($urandom), 8'd1, 100, 100);
    checks++;
    if (obs_cti.size() != 1 || cyc_cnt != 1) begin
      failures++;
      $display("FAIL single_beat beats=%0d cyc_cycles=%0d required 1 and 1", obs_cti.size(), cyc_cnt);
    end
  endtask

  task automatic test_async_reset();
    int k;
    ack_pct = 100;
    rdy_pct = 0;
    err_beat = 0;
    start_req(30'($urandom), 8'd8);
    k = 0;
    while (obs_addr.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, out_valid, req_ready, done} !== 5'b0) begin
      failures++;
      $display("FAIL arst_outputs cyc,stb,vld,rdy,done=%b required 00000",
               {wbm_cyc_o, wbm_stb_o, out_valid, req_ready, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_release rdy=%b vld=%b required 1 and 0", req_ready, out_valid);
    end
    test_transfer(30'($urandom), 8'd8, 100, 100);
  endtask

  task automatic test_random();
    logic [29:0] a;
    for (int t = 0; t < 8; t++) begin
      seed = $urandom;
      a = (t % 2 == 0) ? 30'($urandom) : 30'h3FFF_FFF0 + 30'($urandom_range(15));
      test_transfer(a, 8'($urandom_range(60)), int'($urandom_range(30, 100)),
                    int'($urandom_range(20, 100)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_error();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
